// File: rtl/fetch_pc_gen.sv
// -----------------------------------------------------------------------------
// fetch_pc_gen
//   Next-PC stage in front of the branch predictor. Holds the fetch PC,
//   presents it to the predictor (pc_cur) and to fetch (fetch_pc), and picks
//   the next fetch address from reset / redirect / stall / BTB+predictor /
//   sequential PC+4. A small direct-mapped BTB supplies taken targets.
//
// Ports
//   clk               clock, all state updates on the rising edge
//   rst               synchronous active-low reset
//   stall             fetch queue cannot accept; hold the PC
//   redir_vld/_pc     execute-stage redirect (overrides stall)
//   upd_vld/_pc/_target/_taken
//                     resolved-branch BTB write (taken branches only)
//   pc_cur            current fetch PC to the predictor
//   predict_take      predictor direction for pc_cur, same cycle
//   fetch_pc          PC handed to fetch (same as pc_cur)
//   fetch_vld         fetch_pc valid this cycle
//   fetch_pred_taken  BTB hit and predicted taken
//   fetch_pred_target predicted target, zero when not predicted taken
// -----------------------------------------------------------------------------
module fetch_pc_gen #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          BTB_ENTRIES = 8,
   localparam int         IDX_W       = $clog2(BTB_ENTRIES)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redir_vld,
   input  logic [31:0] redir_pc,
   input  logic        upd_vld,
   input  logic [31:0] upd_pc,
   input  logic [31:0] upd_target,
   input  logic        upd_taken,
   output logic [31:0] pc_cur,
   input  logic        predict_take,
   output logic [31:0] fetch_pc,
   output logic        fetch_vld,
   output logic        fetch_pred_taken,
   output logic [31:0] fetch_pred_target
);

   localparam int TAG_W = 32 - IDX_W - 2;

   logic [31:0]      pc_q, pc_d;
   logic             btb_vld_q [BTB_ENTRIES];
   logic [TAG_W-1:0] btb_tag_q [BTB_ENTRIES];
   logic [31:0]      btb_tgt_q [BTB_ENTRIES];

   logic [IDX_W-1:0] lk_idx;
   logic [TAG_W-1:0] lk_tag;
   logic             lk_hit;
   logic [IDX_W-1:0] wr_idx;
   logic [TAG_W-1:0] wr_tag;
   logic             wr_en;

   // Byte offset of the update PC never reaches the BTB.
   logic unused_upd_bits;
   assign unused_upd_bits = ^upd_pc[1:0];

   // ---------------------------------------------------------------------------
   // Lookup: combinational on the held PC, so a same-cycle update is not seen.
   // ---------------------------------------------------------------------------
   assign lk_idx = pc_q[IDX_W+1:2];
   assign lk_tag = pc_q[31:IDX_W+2];
   assign lk_hit = btb_vld_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);

   assign wr_idx = upd_pc[IDX_W+1:2];
   assign wr_tag = upd_pc[31:IDX_W+2];
   assign wr_en  = rst && upd_vld && upd_taken;

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign pc_cur            = pc_q;
   assign fetch_pc          = pc_q;
   assign fetch_vld         = rst && !stall;
   assign fetch_pred_taken  = lk_hit && predict_take && fetch_vld;
   assign fetch_pred_target = fetch_pred_taken ? btb_tgt_q[lk_idx] : 32'h0;

   // ---------------------------------------------------------------------------
   // Next-PC selection, highest priority first.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: assign a default before any branch so no path leaves pc_d
      // unassigned; otherwise synthesis infers a latch.
      pc_d = pc_q + 32'd4;
      if (!rst) begin
         pc_d = RESET_PC;
      end else if (redir_vld) begin
         pc_d = redir_pc;
      end else if (stall) begin
         pc_d = pc_q;
      end else if (lk_hit && predict_take) begin
         pc_d = btb_tgt_q[lk_idx];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      pc_q <= pc_d;
   end

   // Valid bits are the only BTB state that needs reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < BTB_ENTRIES; i++) btb_vld_q[i] <= 1'b0;
      end else if (wr_en) begin
         btb_vld_q[wr_idx] <= 1'b1;
      end
   end

   // NOTE: tag/target storage is deliberately not reset; an entry is only
   // ever read behind its valid bit, and leaving it unreset keeps it a plain
   // RAM-style array.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         btb_tag_q[wr_idx] <= wr_tag;
         btb_tgt_q[wr_idx] <= upd_target;
      end
   end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_gen
//   Scoreboard bench for fetch_pc_gen. The stimulus process computes the
//   expected outputs of every cycle from a behavioural model and queues them;
//   a monitor pops and compares on each falling edge.
// -----------------------------------------------------------------------------
module tb_fetch_pc_gen;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          ENTRIES  = 8;

   typedef struct {
      logic        chk_pc;
      logic [31:0] pc;
      logic        vld;
      logic        ptaken;
      logic [31:0] ptarget;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, stall, redir_vld, upd_vld, upd_taken, predict_take;
   logic [31:0] redir_pc, upd_pc, upd_target;
   logic [31:0] pc_cur, fetch_pc, fetch_pred_target;
   logic        fetch_vld, fetch_pred_taken;

   int n_checks = 0;
   int n_fail   = 0;

   exp_t sb_q[$];
   exp_t mon_e;

   // Behavioural model state
   logic [31:0] m_pc;
   logic        m_pc_known = 1'b0;
   logic        m_v   [ENTRIES];
   logic [31:0] m_addr[ENTRIES];   // full branch PC stored, compared by line
   logic [31:0] m_tgt [ENTRIES];

   fetch_pc_gen #(.RESET_PC(RESET_PC), .BTB_ENTRIES(ENTRIES)) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .redir_vld(redir_vld), .redir_pc(redir_pc),
      .upd_vld(upd_vld), .upd_pc(upd_pc), .upd_target(upd_target),
      .upd_taken(upd_taken),
      .pc_cur(pc_cur), .predict_take(predict_take),
      .fetch_pc(fetch_pc), .fetch_vld(fetch_vld),
      .fetch_pred_taken(fetch_pred_taken),
      .fetch_pred_target(fetch_pred_target)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Model BTB: entry selected by word address modulo size; a hit needs the
   // stored branch PC to match the looked-up PC in every bit above [1:0].
   function automatic int m_idx(input logic [31:0] a);
      return int'((a >> 2) % ENTRIES);
   endfunction

   function automatic logic m_hit(input logic [31:0] a);
      int i;
      i = m_idx(a);
      return m_v[i] && ((m_addr[i] >> 2) == (a >> 2));
   endfunction

   // One clock cycle: apply inputs, queue expected outputs, advance model.
   task automatic drive(input logic r, s, rv, input logic [31:0] rpc,
                        input logic uv, input logic [31:0] upc, utgt,
                        input logic ut, pt);
      exp_t        e;
      logic        hit;
      logic [31:0] nxt;
      rst = r; stall = s; redir_vld = rv; redir_pc = rpc;
      upd_vld = uv; upd_pc = upc; upd_target = utgt; upd_taken = ut;
      predict_take = pt;

      hit       = m_pc_known && m_hit(m_pc);
      e.chk_pc  = m_pc_known;
      e.pc      = m_pc;
      e.vld     = r && !s;
      e.ptaken  = hit && pt && e.vld;
      e.ptarget = e.ptaken ? m_tgt[m_idx(m_pc)] : 32'h0;
      sb_q.push_back(e);

      @(posedge clk);
      if (!r) begin
         m_pc       = RESET_PC;
         m_pc_known = 1'b1;
         for (int i = 0; i < ENTRIES; i++) m_v[i] = 1'b0;
      end else begin
         if (rv)             nxt = rpc;
         else if (s)         nxt = m_pc;
         else if (hit && pt) nxt = m_tgt[m_idx(m_pc)];
         else                nxt = m_pc + 32'd4;
         m_pc = nxt;
         if (uv && ut) begin
            m_v[m_idx(upc)]    = 1'b1;
            m_addr[m_idx(upc)] = upc;
            m_tgt[m_idx(upc)]  = utgt;
         end
      end
      #1;
   endtask

   task automatic nop(input logic pt);
      drive(1, 0, 0, 0, 0, 0, 0, 0, pt);
   endtask

   task automatic redir(input logic [31:0] a);
      drive(1, 0, 1, a, 0, 0, 0, 0, 0);
   endtask

   // Monitor: compare every cycle's outputs against the queued expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("fetch_vld", {31'b0, fetch_vld}, {31'b0, mon_e.vld});
            check("pred_taken", {31'b0, fetch_pred_taken}, {31'b0, mon_e.ptaken});
            check("pred_target", fetch_pred_target, mon_e.ptarget);
            if (mon_e.chk_pc) begin
               check("pc_cur", pc_cur, mon_e.pc);
               check("fetch_pc", fetch_pc, mon_e.pc);
            end
         end
      end
   end

   initial begin
      rst = 0; stall = 0; redir_vld = 0; redir_pc = 0; upd_vld = 0;
      upd_pc = 0; upd_target = 0; upd_taken = 0; predict_take = 0;
      for (int i = 0; i < ENTRIES; i++) begin
         m_v[i] = 1'b0; m_addr[i] = '0; m_tgt[i] = '0;
      end
      m_pc = '0;
      @(posedge clk); #1;

      // 1. Reset for two cycles, then sequential fetch from RESET_PC.
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("rst_pc", pc_cur, 32'h0);
      // 2. Install 0x10 -> 0x100 while walking 0x0..0xC.
      drive(1, 0, 0, 0, 1, 32'h10, 32'h100, 1, 0);
      check("seq_4", pc_cur, 32'h4);
      nop(0);
      check("seq_8", pc_cur, 32'h8);
      nop(0);
      check("seq_c", pc_cur, 32'hC);
      nop(0);
      check("at_10", pc_cur, 32'h10);
      check("hit_taken", {31'b0, fetch_pred_taken}, 32'h0);  // predict_take still 0
      nop(1);
      check("btb_target", pc_cur, 32'h100);
      redir(32'h10);
      nop(0);
      check("hit_not_taken", pc_cur, 32'h14);

      // 3. Alias at index 4: 0x30 misses, then replaces 0x10.
      redir(32'h30);
      nop(1);
      check("alias_miss", pc_cur, 32'h34);
      drive(1, 0, 1, 32'h30, 1, 32'h30, 32'h200, 1, 0);
      nop(1);
      check("alias_hit", pc_cur, 32'h200);
      redir(32'h10);
      nop(1);
      check("evicted", pc_cur, 32'h14);

      // 4. Not-taken update keeps the entry.
      drive(1, 0, 1, 32'h30, 1, 32'h30, 32'h999, 0, 0);
      nop(1);
      check("nt_retained", pc_cur, 32'h200);

      // 5. Stall holds; redirect overrides stall.
      redir(32'h20);
      drive(1, 1, 0, 0, 0, 0, 0, 0, 1);
      drive(1, 1, 0, 0, 0, 0, 0, 0, 1);
      drive(1, 1, 0, 0, 0, 0, 0, 0, 1);
      check("stall_hold", pc_cur, 32'h20);
      drive(1, 1, 1, 32'h400, 0, 0, 0, 0, 0);
      check("stall_redir", pc_cur, 32'h400);

      // 6. Wrap, then update index 0 while 0x0 is looked up.
      redir(32'hFFFF_FFFC);
      nop(1);
      check("wrap", pc_cur, 32'h0);
      drive(1, 0, 0, 0, 1, 32'h0, 32'h500, 1, 1);
      check("same_cycle_old", pc_cur, 32'h4);
      redir(32'h0);
      nop(1);
      check("same_cycle_new", pc_cur, 32'h500);

      // Mid-run reset discards the BTB.
      drive(0, 0, 0, 0, 1, 32'h40, 32'h80, 1, 1);
      redir(32'h0);
      nop(1);
      check("rst_clears_btb", pc_cur, 32'h4);

      // Randomized traffic over a small address pool so hits are frequent.
      for (int n = 0; n < 600; n++) begin
         logic        r, s, rv, uv, ut, pt;
         logic [31:0] rpc, upc, utgt;
         r    = ($urandom_range(0, 59) != 0);
         s    = ($urandom_range(0, 3) == 0);
         rv   = ($urandom_range(0, 7) == 0);
         uv   = ($urandom_range(0, 2) == 0);
         ut   = $urandom_range(0, 1);
         pt   = $urandom_range(0, 1);
         rpc  = {($urandom_range(0, 3) == 0) ? 24'hFFFF_FF : 24'h0,
                 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
         upc  = {($urandom_range(0, 3) == 0) ? 24'hFFFF_FF : 24'h0,
                 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
         utgt = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
         drive(r, s, rv, rpc, uv, upc, utgt, ut, pt);
      end

      repeat (2) @(negedge clk);
      check("sb_drained", sb_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
Front-end next-PC stage that sits directly upstream of the branch predictor. Holds the fetch PC and drives it to the predictor as pc_cur. Combines the predictor's predict_take with a small direct-mapped branch target buffer (BTB) to choose the next fetch address. Applies redirects from execute and stall back-pressure from the fetch queue.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset
BTB_ENTRIES, 8, number of BTB entries; power of two, >=2
IDX_W, $clog2(BTB_ENTRIES), BTB index width (derived, not overridden)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-low reset
stall  in  1  downstream cannot accept; hold PC
redir_vld  in  1  execute-stage redirect request
redir_pc  in  32  redirect target
upd_vld  in  1  resolved-branch BTB update strobe
upd_pc  in  32  PC of resolved branch
upd_target  in  32  resolved branch target
upd_taken  in  1  resolved direction
pc_cur  out  32  current fetch PC to predictor
predict_take  in  1  predictor direction for pc_cur, valid in the same cycle
fetch_pc  out  32  PC handed to fetch (equals pc_cur)
fetch_vld  out  1  fetch_pc valid this cycle
fetch_pred_taken  out  1  PC was predicted taken (BTB hit and predict_take)
fetch_pred_target  out  32  predicted target; 0 when fetch_pred_taken=0

Behaviour:
- Reset (rst=0 at posedge): PC reg <= RESET_PC; all BTB valid bits cleared; fetch_vld=0 while rst=0 and for no cycle after. pc_cur=RESET_PC. fetch_pred_taken=0, fetch_pred_target=0 while in reset.
- BTB: direct-mapped. Index = pc[IDX_W+1:2]. Tag = pc[31:IDX_W+2]. Each entry holds valid, tag and target. pc[1:0] is ignored.
- Lookup is combinational on the PC reg. hit = valid & (tag match).
- fetch_pred_taken = hit & predict_take & fetch_vld. fetch_pred_target = entry target when fetch_pred_taken=1, else 0.
- fetch_vld = rst & ~stall.
- Next-PC priority (registered, one-cycle latency), highest first:
  1. reset -> RESET_PC
  2. redir_vld -> redir_pc; a redirect overrides stall
  3. stall -> hold
  4. hit & predict_take -> BTB target
  5. otherwise -> PC+4, mod 2^32 (0xFFFF_FFFC wraps to 0x0)
- BTB update on posedge when upd_vld=1:
  - upd_taken=1: write valid=1, tag and target at upd_pc's index, overwriting any aliasing entry.
  - upd_taken=0: no change. Entries are never invalidated except by reset.
- An update and a lookup to the same index in the same cycle: the lookup sees the old contents; the new entry is visible from the next cycle.
- Updates are accepted during stall and during redirect. Updates are ignored while in reset.
- Reset mid-operation: all state discarded; the first valid fetch is RESET_PC in the cycle rst returns high.

Test Plan:
1. Reset: hold rst=0 for 2 cycles, then release with stall=0, predict_take=0 -> fetch_vld=0 during reset; then pc_cur = 0x0, 0x4, 0x8, 0xC on consecutive cycles, fetch_pred_taken=0.
2. BTB hit: upd_vld=1, upd_pc=0x10, upd_target=0x100, upd_taken=1. Then fetch to 0x10 with predict_take=1 -> fetch_pred_taken=1, fetch_pred_target=0x100, next pc_cur=0x100. Repeat with predict_take=0 -> next pc_cur=0x14, fetch_pred_taken=0.
3. Alias/replacement: after scenario 2, fetch 0x30 (same index 4, different tag) with predict_take=1 -> miss, next pc_cur=0x34. Then update upd_pc=0x30, target 0x200, taken -> fetch 0x30 goes to 0x200, and fetch 0x10 now misses and goes to 0x14.
4. Not-taken update: upd_pc=0x30, upd_taken=0 -> entry retained; fetch 0x30 with predict_take=1 still goes to 0x200.
5. Stall/redirect: stall=1 for 3 cycles at pc 0x20 -> pc_cur holds 0x20, fetch_vld=0. Then stall=1 and redir_vld=1, redir_pc=0x400 together -> next pc_cur=0x400.
6. Wrap and same-cycle hazard: redirect to 0xFFFF_FFFC -> next pc_cur=0x0. Update index 0 in the same cycle pc_cur=0x0 is looked up -> old entry used (miss), pc_cur=0x4.
